// File: rtl/fixed_pkg.sv
// Shared constants and types for the sign-magnitude fixed-point datapath
// (multiplier and divider).
package fixed_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_FIXED_POINT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Sign in the top bit, magnitude below it.
    typedef struct packed {
        logic                          sign;
        logic [DEF_DATA_WIDTH-2:0]     mag;
    } sm_word_t;

endpackage

// File: rtl/fixed_div_step.sv
// One restoring-division step: shift in a numerator bit, then compare against
// the divisor and subtract when the shifted remainder is large enough.
module fixed_div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem_in,
    input  logic                  bit_in,
    input  logic [DATA_WIDTH-2:0] divisor,
    output logic [DATA_WIDTH-1:0] rem_out,
    output logic                  q_bit
);

    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] dvs_ext;

    assign shifted = {rem_in[DATA_WIDTH-2:0], bit_in};
    assign dvs_ext = {1'b0, divisor};
    // A set remainder MSB would push the shifted value past any divisor.
    assign q_bit   = rem_in[DATA_WIDTH-1] | (shifted >= dvs_ext);
    assign rem_out = q_bit ? (shifted - dvs_ext) : shifted;

endmodule

// File: rtl/fixed_divider.sv
// Iterative sign-magnitude fixed-point divider, one quotient bit per cycle.
// Optional build macro FIXED_DIVIDER_OVF_SAT_EN saturates the magnitude on overflow.
module fixed_divider
    import fixed_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int FIXED_POINT = DEF_FIXED_POINT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] C,
    output logic                  div_by_zero,
    output logic                  overflow,
    output logic [1:0]            dbg_state
);

    localparam int N  = DATA_WIDTH - 1 + FIXED_POINT;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; in_ready only in IDLE, out_valid only in DONE, so an input is
    // never taken on the same edge a result is consumed.
    div_state_t            state;
    logic [CW-1:0]         count;
    logic [N-1:0]          num;
    logic [N-2:0]          quo;
    logic [DATA_WIDTH-1:0] rem;
    logic [DATA_WIDTH-2:0] dvs;
    logic                  sign_q;

    logic [DATA_WIDTH-1:0] rem_next;
    logic                  q_bit;
    logic [N-1:0]          q_final;
    logic                  ovf_next;
    logic [DATA_WIDTH-2:0] mag_next;

    fixed_div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .rem_in  (rem),
        .bit_in  (num[N-1]),
        .divisor (dvs),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    assign q_final  = {quo, q_bit};
    assign ovf_next = |q_final[N-1:DATA_WIDTH-1];

`ifdef FIXED_DIVIDER_OVF_SAT_EN
    assign mag_next = ovf_next ? '1 : q_final[DATA_WIDTH-2:0];
`else
    assign mag_next = q_final[DATA_WIDTH-2:0];
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            num         <= '0;
            quo         <= '0;
            rem         <= '0;
            dvs         <= '0;
            sign_q      <= 1'b0;
            C           <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q <= A[DATA_WIDTH-1] ^ B[DATA_WIDTH-1];
                        dvs    <= B[DATA_WIDTH-2:0];
                        num    <= {A[DATA_WIDTH-2:0], {FIXED_POINT{1'b0}}};
                        rem    <= '0;
                        quo    <= '0;
                        count  <= LAST_STEP;
                        if (~|B[DATA_WIDTH-2:0]) begin
                            state       <= DONE;
                            C           <= {A[DATA_WIDTH-1] ^ B[DATA_WIDTH-1], {(DATA_WIDTH-1){1'b1}}};
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    num   <= {num[N-2:0], 1'b0};
                    rem   <= rem_next;
                    quo   <= {quo[N-3:0], q_bit};
                    count <= count - 1'b1;
                    if (count == '0) begin
                        state       <= DONE;
                        C           <= {sign_q, mag_next};
                        div_by_zero <= 1'b0;
                        overflow    <= ovf_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_divider.sv
// Self-checking bench for fixed_divider: arithmetic reference model, expected
// queue, directed vectors, backpressure, mid-operation reset and random ops.
module tb_fixed_divider;

    localparam int DW = 32;
    localparam int FP = 16;
    localparam int N  = DW - 1 + FP;
    localparam int W  = DW + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] a_in = '0;
    logic [DW-1:0] b_in = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] c_out;
    logic          div_by_zero;
    logic          overflow;
    logic [1:0]    dbg_state;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    fixed_divider #(.DATA_WIDTH(DW), .FIXED_POINT(FP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .A           (a_in),
        .B           (b_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .C           (c_out),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Reference: {C, div_by_zero, overflow} from plain 64-bit arithmetic.
    function automatic logic [W-1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [63:0]   num;
        logic [63:0]   q;
        logic [DW-2:0] mag;
        logic          s;
        logic          ovf;
        s = a[DW-1] ^ b[DW-1];
        if (b[DW-2:0] == '0) return {s, {(DW-1){1'b1}}, 1'b1, 1'b0};
        num = {33'b0, a[DW-2:0]} << FP;
        q   = num / {33'b0, b[DW-2:0]};
        ovf = (q >> (DW - 1)) != 64'd0;
        mag = q[DW-2:0];
`ifdef FIXED_DIVIDER_OVF_SAT_EN
        if (ovf) mag = '1;
`endif
        return {s, mag, 1'b0, ovf};
    endfunction

    function automatic logic [DW-1:0] rand_op();
        logic          s;
        logic [DW-2:0] m;
        int            r;
        r = $urandom_range(0, 9);
        s = 1'($urandom_range(0, 1));
        if (r == 0)      m = '0;
        else if (r <= 3) m = 31'($urandom_range(1, 255));
        else if (r <= 5) m = 31'($urandom_range(1, 255)) << FP;
        else             m = 31'($urandom);
        return {s, m};
    endfunction

    // Result checker: whenever out_valid is up, the held outputs must match
    // the oldest outstanding expectation; it retires when out_ready is high.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out_valid: got C=%0h want no result", c_out);
            end else begin
                check("result", 64'({c_out, div_by_zero, overflow}), 64'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic accept(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int w;
        w = 0;
        while (!in_ready && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        exp_q.push_back(model(a, b));
        @(posedge clk); #1;
        in_valid = 1'b0;
        a_in     = $urandom;
        b_in     = $urandom;
        check("in_ready_after_accept", 64'(in_ready), 64'd0);
    endtask

    // Latency is the number of edges after the accepting edge before out_valid.
    task automatic finish_op(input bit dz, input int hold);
        int lat;
        lat = 0;
        while (!out_valid && lat < N + 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), dz ? 64'd0 : 64'(N));
        if (!out_valid) return;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("in_ready_while_held", 64'(in_ready), 64'd0);
            check("out_valid_while_held", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_after_consume", 64'(out_valid), 64'd0);
        check("in_ready_after_consume", 64'(in_ready), 64'd1);
    endtask

    task automatic do_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input int hold);
        accept(a, b);
        finish_op(b[DW-2:0] == '0, hold);
    endtask

    initial begin
        bit saw_valid;

        // Hand-computed pins on the model itself.
        check("pin_3_div_2", 64'(model(32'h0003_0000, 32'h0002_0000)), 64'({32'h0001_8000, 2'b00}));
        check("pin_neg", 64'(model(32'h8001_0000, 32'h0004_0000)), 64'({32'h8000_4000, 2'b00}));
        check("pin_third", 64'(model(32'h0001_0000, 32'h0003_0000)), 64'({32'h0000_5555, 2'b00}));
        check("pin_dz", 64'(model(32'h0001_0000, 32'h0000_0000)), 64'({32'h7FFF_FFFF, 2'b10}));
`ifdef FIXED_DIVIDER_OVF_SAT_EN
        check("pin_ovf", 64'(model(32'h7FFF_0000, 32'h0000_0001)), 64'({32'h7FFF_FFFF, 2'b01}));
`else
        check("pin_ovf", 64'(model(32'h7FFF_0000, 32'h0000_0001)), 64'({32'h0000_0000, 2'b01}));
`endif

        #2 rst_n = 1'b0;
        #1;
        check("reset_c", 64'(c_out), 64'd0);
        check("reset_dz", 64'(div_by_zero), 64'd0);
        check("reset_ovf", 64'(overflow), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(32'h0003_0000, 32'h0002_0000, 10);
        do_op(32'h8001_0000, 32'h0004_0000, 0);
        do_op(32'h0001_0000, 32'h0003_0000, 2);
        do_op(32'h0001_0000, 32'h0000_0000, 1);
        do_op(32'h8001_0000, 32'h0000_0000, 0);
        do_op(32'h7FFF_0000, 32'h0000_0001, 0);
        do_op(32'h8000_0000, 32'h0001_0000, 1);
        do_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);

        // Asynchronous reset in the middle of a calculation.
        accept(32'h0005_0000, 32'h0002_0000);
        repeat (20) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midreset_c", 64'(c_out), 64'd0);
        check("midreset_dz", 64'(div_by_zero), 64'd0);
        check("midreset_ovf", 64'(overflow), 64'd0);
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < N + 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check("no_out_valid_after_reset", 64'(saw_valid), 64'd0);
        do_op(32'h0003_0000, 32'h0002_0000, 0);

        for (int i = 0; i < 40; i++) begin
            logic [DW-1:0] ra;
            logic [DW-1:0] rb;
            ra = rand_op();
            rb = rand_op();
            do_op(ra, rb, $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
